// File: rtl/kiana_pkg.sv
// -----------------------------------------------------------------------------
// kiana_pkg
// Shared constants and types for the warp issue stage.
//   NUM_WARPS : number of hardware warps
//   WARP_ID_W : warp id width (clog2 of NUM_WARPS)
//   PC_W      : program counter width
//   PC_STEP   : PC increment applied on every issued instruction
// -----------------------------------------------------------------------------
package kiana_pkg;

  localparam int NUM_WARPS = 32;
  localparam int WARP_ID_W = $clog2(NUM_WARPS);
  localparam int PC_W      = 32;

  typedef logic [WARP_ID_W-1:0] warp_id_t;
  typedef logic [PC_W-1:0]      pc_t;

  localparam pc_t PC_STEP = PC_W'(4);

  // Next warp id after 'id', wrapping from NUM_WARPS-1 back to 0. Written
  // explicitly so it stays correct if NUM_WARPS is not a power of two.
  function automatic warp_id_t wrap_inc(input warp_id_t id);
    if (int'(id) == NUM_WARPS - 1) begin
      return '0;
    end
    return id + warp_id_t'(1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: the first asserted request at or
// after 'ptr', wrapping at NUM_WARPS-1.
//   req         : per-warp request vector
//   ptr         : search start position
//   grant_valid : at least one request is asserted
//   grant_id    : chosen requester
//   is_last     : no request exists with an id above grant_id, i.e. the
//                 next pick will wrap around
// -----------------------------------------------------------------------------
module rr_arbiter
  import kiana_pkg::*;
(
  input  logic [NUM_WARPS-1:0] req,
  input  logic [WARP_ID_W-1:0] ptr,
  output logic                 grant_valid,
  output logic [WARP_ID_W-1:0] grant_id,
  output logic                 is_last
);

  always_comb begin
    int v_idx;
    v_idx       = 0;
    grant_valid = 1'b0;
    grant_id    = '0;
    is_last     = 1'b0;

    // Walk offsets 0..NUM_WARPS-1 from ptr; the first hit wins.
    for (int k = 0; k < NUM_WARPS; k++) begin
      v_idx = int'(ptr) + k;
      if (v_idx >= NUM_WARPS) begin
        v_idx = v_idx - NUM_WARPS;
      end
      if (!grant_valid && req[WARP_ID_W'(v_idx)]) begin
        grant_valid = 1'b1;
        grant_id    = WARP_ID_W'(v_idx);
      end
    end

    // "Last" looks at absolute ids, not at the rotated order: it flags that
    // nothing numerically above the winner is still waiting.
    if (grant_valid) begin
      is_last = 1'b1;
      for (int k = 0; k < NUM_WARPS; k++) begin
        if ((k > int'(grant_id)) && req[WARP_ID_W'(k)]) begin
          is_last = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/warp_scheduler.sv
// -----------------------------------------------------------------------------
// warp_scheduler
// Round-robin warp issue stage feeding the instruction cache. Tracks active,
// in-flight and PC state per warp and issues one ready warp per cycle.
//   clk, rst          : clock, asynchronous active-high reset
//   launch_*          : start an inactive warp at launch_pc
//   cpl_*             : back-end completion (clear in-flight, redirect, exit)
//   i_stall           : downstream back-pressure, suppresses this cycle's issue
//   selected_warp_id  : issued warp id (holds when nothing issues)
//   selected_pc       : issued PC (holds when nothing issues)
//   s_tvalid          : an issue happened
//   s_tlast           : issued warp is the last ready one before wrap-around
//   active_mask       : per-warp active bits
// -----------------------------------------------------------------------------
module warp_scheduler
  import kiana_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 launch_valid,
  input  logic [WARP_ID_W-1:0] launch_warp_id,
  input  logic [PC_W-1:0]      launch_pc,
  input  logic                 cpl_valid,
  input  logic [WARP_ID_W-1:0] cpl_warp_id,
  input  logic                 cpl_redirect,
  input  logic [PC_W-1:0]      cpl_target,
  input  logic                 cpl_exit,
  input  logic                 i_stall,
  output logic [WARP_ID_W-1:0] selected_warp_id,
  output logic [PC_W-1:0]      selected_pc,
  output logic                 s_tvalid,
  output logic                 s_tlast,
  output logic [NUM_WARPS-1:0] active_mask
);

  // Gathered view of the per-warp state held in the generate blocks below.
  logic [NUM_WARPS-1:0]           w_active;
  logic [NUM_WARPS-1:0]           w_in_flight;
  logic [NUM_WARPS-1:0][PC_W-1:0] w_pc;
  logic [NUM_WARPS-1:0]           w_ready;

  // Arbiter results and the issue decision for this cycle.
  logic     w_grant_valid;
  warp_id_t w_grant_id;
  logic     w_is_last;
  logic     w_issue;

  // Issue-side registers.
  warp_id_t r_rr_ptr;
  warp_id_t r_sel_id;
  pc_t      r_sel_pc;
  logic     r_tvalid;
  logic     r_tlast;

  assign w_ready = w_active & ~w_in_flight;
  assign w_issue = w_grant_valid & ~i_stall;

  rr_arbiter u_rr_arbiter (
    .req         (w_ready),
    .ptr         (r_rr_ptr),
    .grant_valid (w_grant_valid),
    .grant_id    (w_grant_id),
    .is_last     (w_is_last)
  );

  // ---------------------------------------------------------------------------
  // Per-warp state. The three events are mutually exclusive per warp by
  // construction: launch needs the warp inactive, issue needs it active and
  // idle, completion needs it in flight. The if/else order only matters for
  // illegal combinations and keeps each warp's update single-sourced.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
      logic r_active;
      logic r_in_flight;
      pc_t  r_pc;
      logic w_launch_hit;
      logic w_cpl_hit;
      logic w_issue_hit;

      assign w_launch_hit = launch_valid && (launch_warp_id == WARP_ID_W'(gi)) && !r_active;
      // A completion for a warp that is not in flight (including one that is
      // being launched this same cycle) is dropped.
      assign w_cpl_hit    = cpl_valid && (cpl_warp_id == WARP_ID_W'(gi)) && r_in_flight;
      assign w_issue_hit  = w_issue && (w_grant_id == WARP_ID_W'(gi));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_active    <= 1'b0;
          r_in_flight <= 1'b0;
          r_pc        <= '0;
        end else if (w_launch_hit) begin
          r_active    <= 1'b1;
          r_in_flight <= 1'b0;
          r_pc        <= launch_pc;
        end else if (w_cpl_hit) begin
          r_in_flight <= 1'b0;
          // Exit wins over redirect and leaves the PC untouched.
          if (cpl_exit) begin
            r_active <= 1'b0;
          end else if (cpl_redirect) begin
            r_pc <= cpl_target;
          end
        end else if (w_issue_hit) begin
          r_in_flight <= 1'b1;
          r_pc        <= r_pc + PC_STEP;
        end
      end

      assign w_active[gi]    = r_active;
      assign w_in_flight[gi] = r_in_flight;
      assign w_pc[gi]        = r_pc;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Issue registers. When nothing issues, id/PC hold their last values while
  // valid/last drop; the round-robin pointer only moves on an actual issue so
  // a stall never skips a warp.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_sel_id <= '0;
      r_sel_pc <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
    end else if (w_issue) begin
      r_rr_ptr <= wrap_inc(w_grant_id);
      r_sel_id <= w_grant_id;
      r_sel_pc <= w_pc[w_grant_id];
      r_tvalid <= 1'b1;
      r_tlast  <= w_is_last;
    end else begin
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
    end
  end

  assign selected_warp_id = r_sel_id;
  assign selected_pc      = r_sel_pc;
  assign s_tvalid         = r_tvalid;
  assign s_tlast          = r_tlast;
  assign active_mask      = w_active;

endmodule
